// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute/writeback control FSM
// for a single-issue RV32I integer datapath.
//   - Fetches one instruction per pass over a valid/ready imem port.
//   - Holds the instruction word in a register for the external decoder.
//   - Sends a single ex_en pulse, then one gated rf_we pulse.
//   - Halts on ECALL, or (with trap) on any opcode other than OP/OP-IMM.
// Optional build macro: INSTR_SEQ_RETIRE_CNT_EN enables the 32-bit retired
// instruction counter. Without it, retired is tied to zero.
module instr_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     instr,
    input  logic            dec_reg_we,
    output logic            rf_we,
    output logic            ex_en,
    output logic [XLEN-1:0] pc,
    output logic            halted,
    output logic            trap,
    output logic [31:0]     retired
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_FETCH_REQ  = 3'd1;
    localparam logic [2:0] S_FETCH_WAIT = 3'd2;
    localparam logic [2:0] S_DECODE     = 3'd3;
    localparam logic [2:0] S_EXECUTE    = 3'd4;
    localparam logic [2:0] S_WRITEBACK  = 3'd5;
    localparam logic [2:0] S_HALT       = 3'd6;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;

    logic [2:0] state;
    logic       wb_cyc;

    // The strobes are decoded from the state. They are therefore 0 in reset,
    // IDLE and HALT, and the single-cycle states give single-cycle pulses.
    assign wb_cyc         = (state == S_WRITEBACK);
    assign imem_req_valid = (state == S_FETCH_REQ);
    assign imem_addr      = pc;
    assign ex_en          = (state == S_EXECUTE);
    // A write to x0 is architecturally a no-op, so it is suppressed here.
    assign rf_we          = wb_cyc && dec_reg_we && (instr[11:7] != 5'd0);

    // Main FSM: state, PC, instruction register and the sticky halt/trap flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            instr  <= NOP;
            halted <= 1'b0;
            trap   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) state <= S_FETCH_REQ;
                end
                S_FETCH_REQ: begin
                    if (imem_req_ready) state <= S_FETCH_WAIT;
                end
                S_FETCH_WAIT: begin
                    if (imem_rsp_valid) begin
                        instr <= imem_rsp_data;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (instr[6:0] == OPC_OP || instr[6:0] == OPC_OP_IMM) begin
                        state <= S_EXECUTE;
                    end else begin
                        // The PC stays on the offending instruction for debug.
                        state  <= S_HALT;
                        halted <= 1'b1;
                        trap   <= (instr != ECALL);
                    end
                end
                S_EXECUTE: begin
                    state <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    pc    <= pc + XLEN'(4);
                    state <= run ? S_FETCH_REQ : S_IDLE;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef INSTR_SEQ_RETIRE_CNT_EN
    logic [31:0] retired_q;

    // Count each instruction that reaches writeback. The count wraps silently.
    always_ff @(posedge clk) begin
        if (!rst_n)      retired_q <= '0;
        else if (wb_cyc) retired_q <= retired_q + 32'd1;
    end

    assign retired = retired_q;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer. The tests cover:
//   - reset values, and zero-wait timing;
//   - a stalled request and a delayed response;
//   - a write to x0, and dropping run mid-fetch;
//   - ECALL and illegal-opcode halts, and reset during a fetch;
//   - PC wrap, on a second instance whose RESET_PC is 32'hFFFF_FFFC.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, run, imem_req_ready, imem_rsp_valid, dec_reg_we;
    logic [31:0] imem_rsp_data;
    logic        imem_req_valid, rf_we, ex_en, halted, trap;
    logic [31:0] imem_addr, instr, pc, retired;
    logic        w_req_valid, w_rf_we, w_ex_en, w_halted, w_trap;
    logic [31:0] w_addr, w_instr, w_pc, w_retired;

    int n_vec = 0;
    int n_err = 0;
    int exp_ret;

    always #5 clk = ~clk;

    instr_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr(instr), .dec_reg_we(dec_reg_we),
        .rf_we(rf_we), .ex_en(ex_en), .pc(pc), .halted(halted), .trap(trap),
        .retired(retired)
    );

    instr_sequencer #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(w_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr(w_instr), .dec_reg_we(dec_reg_we),
        .rf_we(w_rf_we), .ex_en(w_ex_en), .pc(w_pc), .halted(w_halted),
        .trap(w_trap), .retired(w_retired)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int ret_exp(input int n);
`ifdef INSTR_SEQ_RETIRE_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_strobes", {30'd0, rf_we, ex_en}, 32'd0);
        chk("rst_flags", {30'd0, halted, trap}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        rst_n = 1'b1;
    endtask

    // Returns at the negedge right after the capture, with the DUT in DECODE.
    task automatic fetch(input logic [31:0] word, input logic [31:0] exp_pc,
                         input int req_wait, input int rsp_wait, input bit drop_run);
        logic [31:0] old_instr;
        int n;
        n = 0;
        while (!imem_req_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", 32'(imem_req_valid), 32'd1);
        chk("req_addr", imem_addr, exp_pc);
        old_instr = instr;
        for (int i = 0; i < req_wait; i++) begin
            // A response that arrives before the handshake must be ignored.
            imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0003;
            @(negedge clk);
            imem_rsp_valid = 1'b0;
            chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
            chk("req_hold_addr", imem_addr, exp_pc);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        if (drop_run) run = 1'b0;
        chk("wait_no_req", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < rsp_wait - 1; i++) begin
            @(negedge clk);
            chk("wait_no_req", 32'(imem_req_valid), 32'd0);
            chk("wait_instr_hold", instr, old_instr);
        end
        imem_rsp_valid = 1'b1; imem_rsp_data = word;
        @(negedge clk);
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        chk("instr_capture", instr, word);
    endtask

    task automatic pulses(input int n, output int we, output int ex);
        we = 0; ex = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            we += int'(rf_we);
            ex += int'(ex_en);
            if (rf_we && ex_en) chk("we_ex_overlap", 32'd1, 32'd0);
        end
    endtask

    initial begin
        int we, ex;
        dec_reg_we = 1'b1;
        @(negedge clk);
        do_reset();
        run = 1'b1;

        // Zero-wait addi x1,x0,5: the request is in cycle 1 and rf_we in cycle 5.
        @(negedge clk);
        chk("t1_req_cycle1", 32'(imem_req_valid), 32'd1);
        fetch(32'h0050_0093, 32'h0, 0, 1, 1'b0);
        @(negedge clk);
        chk("t1_ex_en", {30'd0, ex_en, rf_we}, 32'd2);
        @(negedge clk);
        chk("t1_rf_we", {30'd0, ex_en, rf_we}, 32'd1);
        chk("t1_pc_in_wb", pc, 32'h0);
        @(negedge clk);
        chk("t1_rf_we_drop", 32'(rf_we), 32'd0);
        chk("t1_pc", pc, 32'h4);
        chk("t1_wrap_pc", w_pc, 32'h0);
        chk("t1_retired", retired, 32'(ret_exp(1)));
        chk("t1_back_to_back", 32'(imem_req_valid), 32'd1);

        // The request stalls for 3 cycles, and the response arrives 4 cycles later.
        fetch(32'h00A0_0113, 32'h4, 3, 4, 1'b0);
        pulses(2, we, ex);
        chk("t2_we_cnt", 32'(we), 32'd1);
        chk("t2_ex_cnt", 32'(ex), 32'd1);

        // addi x0,x0,0 with dec_reg_we=1 must not write.
        fetch(32'h0000_0013, 32'h8, 0, 1, 1'b0);
        pulses(2, we, ex);
        chk("t3_we_x0", 32'(we), 32'd0);
        @(negedge clk);
        chk("t3_pc", pc, 32'hC);

        // run drops in FETCH_WAIT. The instruction still retires, then the FSM idles.
        fetch(32'h0030_0193, 32'hC, 0, 2, 1'b1);
        pulses(2, we, ex);
        chk("t4_we_cnt", 32'(we), 32'd1);
        repeat (2) @(negedge clk);
        chk("t4_idle_no_req", 32'(imem_req_valid), 32'd0);
        chk("t4_pc", pc, 32'h10);
        chk("t4_retired", retired, 32'(ret_exp(4)));
        run = 1'b1;

        // ECALL halts without a trap.
        fetch(32'h0000_0073, 32'h10, 0, 1, 1'b0);
        @(negedge clk);
        chk("t5_ecall_flags", {30'd0, halted, trap}, 32'd2);
        chk("t5_ecall_pc", pc, 32'h10);

        // A load opcode halts with a trap, and toggling run has no effect.
        do_reset();
        run = 1'b1;
        fetch(32'h0000_0003, 32'h0, 0, 1, 1'b0);
        pulses(4, we, ex);
        chk("t6_no_we", 32'(we + ex), 32'd0);
        chk("t6_flags", {30'd0, halted, trap}, 32'd3);
        chk("t6_pc", pc, 32'h0);
        run = 1'b0;
        repeat (2) @(negedge clk);
        run = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_halt_no_req", 32'(imem_req_valid), 32'd0);
        chk("t6_halt_sticky", {30'd0, halted, trap}, 32'd3);

        // Reset in FETCH_WAIT. A response one cycle later is ignored.
        do_reset();
        run = 1'b1;
        begin
            int n;
            n = 0;
            while (!imem_req_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("t7_req_seen", 32'(imem_req_valid), 32'd1);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; run = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093;
        @(negedge clk);
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        pulses(3, we, ex);
        chk("t7_instr", instr, 32'h0000_0013);
        chk("t7_pc", pc, 32'h0);
        chk("t7_no_req", 32'(imem_req_valid), 32'd0);
        chk("t7_no_we", 32'(we + ex), 32'd0);
        chk("t7_wrap_halted", 32'(w_halted), 32'(halted));

        exp_ret = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
